// File: rtl/sum_inverse_fsm.sv
// Inverse triangular sum: finds the largest n with 0+1+...+n <= sum_in by
// repeated subtraction, reporting the remainder and an exact-triangular flag.
module sum_inverse_fsm #(
  parameter int SUM_W = 8,
  parameter int N_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] sum_in,
  output logic [N_W-1:0]   n_out,
  output logic [SUM_W-1:0] rem_out,
  output logic             exact,
  output logic             busy,
  output logic             valid
);

  localparam int CMP_W = (SUM_W > N_W + 1) ? SUM_W : N_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SUM_W-1:0] rem;
  logic [N_W:0]     k;
  logic [N_W-1:0]   n;
  logic             take;

  // k is one bit wider than n so it can reach n_max+1 without wrapping.
  assign take  = CMP_W'(rem) >= CMP_W'(k);
  assign busy  = (state == RUN);
  assign valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: next-state is defaulted first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (!take) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem     <= '0;
      k       <= '0;
      n       <= '0;
      n_out   <= '0;
      rem_out <= '0;
      exact   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rem <= sum_in;
            k   <= (N_W+1)'(1);
            n   <= '0;
          end
        end
        RUN: begin
          if (take) begin
            // take guarantees k <= rem, so the narrowing casts are lossless.
            rem <= rem - SUM_W'(k);
            n   <= N_W'(k);
            k   <= k + (N_W+1)'(1);
          end else begin
            n_out   <= n;
            rem_out <= rem;
            exact   <= (rem == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_inverse_fsm.sv
// Scoreboard bench for sum_inverse_fsm: the driver queues expected results,
// the monitor pops and compares on each rising edge of valid.
module tb_sum_inverse_fsm;

  typedef struct packed {
    logic [4:0] n;
    logic [7:0] rem;
    logic       exact;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] sum_in;
  logic [4:0] n_out;
  logic [7:0] rem_out;
  logic       exact;
  logic       busy;
  logic       valid;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic valid_q = 1'b0;

  sum_inverse_fsm #(.SUM_W(8), .N_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sum_in  (sum_in),
    .n_out   (n_out),
    .rem_out (rem_out),
    .exact   (exact),
    .busy    (busy),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: count up triangular numbers directly rather than subtracting.
  function automatic exp_t model(input int s);
    exp_t e;
    int   m = 0;
    while ((m + 1) * (m + 2) / 2 <= s) m++;
    e.n     = 5'(m);
    e.rem   = 8'(s - m * (m + 1) / 2);
    e.exact = (s == m * (m + 1) / 2);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && valid && !valid_q) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("n_out", 32'(n_out), 32'(mon_e.n));
        check("rem_out", 32'(rem_out), 32'(mon_e.rem));
        check("exact", 32'(exact), 32'(mon_e.exact));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
    valid_q = valid;
  end

  // Issue one request and check latency n+1; with hold=0 start is dropped
  // after acceptance and DONE must fall back to IDLE one edge later.
  task automatic run_op(input logic [7:0] s, input exp_t e, input bit hold);
    int cyc;
    @(negedge clk);
    sum_in = s;
    start  = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    check("busy_after_accept", 32'(busy), 32'd1);
    if (!hold) start = 1'b0;
    cyc = 0;
    while (!valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 32'(e.n) + 32'd1);
    if (!hold) begin
      @(negedge clk);
      check("valid_one_cycle", 32'(valid), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    rst    = 1'b0;
    start  = 1'b0;
    sum_in = 8'd0;
    #12;
    check("rst_n_out", 32'(n_out), 32'd0);
    check("rst_rem_out", 32'(rem_out), 32'd0);
    check("rst_exact", 32'(exact), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // S=10 with start held: one computation, outputs hold through DONE.
    run_op(8'd10, '{5'd4, 8'd0, 1'b1}, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_valid", 32'(valid), 32'd1);
    check("hold_n_out", 32'(n_out), 32'd4);
    check("hold_exact", 32'(exact), 32'd1);
    check("hold_busy", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    check("drop_valid", 32'(valid), 32'd0);
    check("idle_keep_n_out", 32'(n_out), 32'd4);

    run_op(8'd12,  '{5'd4,  8'd2, 1'b0}, 1'b0);
    run_op(8'd0,   '{5'd0,  8'd0, 1'b1}, 1'b0);
    run_op(8'd255, '{5'd22, 8'd2, 1'b0}, 1'b0);

    // S=21 accepted, then sum_in changed and start dropped during RUN.
    @(negedge clk);
    sum_in = 8'd21;
    start  = 1'b1;
    sb_q.push_back('{5'd6, 8'd0, 1'b1});
    @(negedge clk);
    sum_in = 8'd5;
    start  = 1'b0;
    cyc = 0;
    while (!valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    check("latency_21", cyc, 32'd7);
    @(negedge clk);
    check("valid_one_cycle_21", 32'(valid), 32'd0);
    check("retain_n_out_21", 32'(n_out), 32'd6);
    check("retain_exact_21", 32'(exact), 32'd1);

    // S=200, reset asserted just after edge 3: async clear, result discarded.
    @(negedge clk);
    sum_in = 8'd200;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_n_out", 32'(n_out), 32'd0);
    check("arst_rem_out", 32'(rem_out), 32'd0);
    check("arst_exact", 32'(exact), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_stays_idle", 32'(busy), 32'd0);
    run_op(8'd6, '{5'd3, 8'd0, 1'b1}, 1'b0);

    // Full sweep against the reference model.
    for (int s = 0; s < 256; s++) run_op(8'(s), model(s), 1'b0);

    // Loopback: forward triangular sums must invert to t with exact=1.
    for (int t = 0; t <= 22; t++) run_op(8'(t * (t + 1) / 2), '{5'(t), 8'd0, 1'b1}, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_inverse_fsm.md
Name: sum_inverse_fsm

Overview:
- Inverse of the triangular-sum block: given a sum S, finds the largest n with 0+1+...+n <= S.
- Also reports remainder R = S - n(n+1)/2 and whether S is an exact triangular number.
- Uses the same enable-style level handshake as the forward summing FSM, so the two can be chained in a loopback self-check on the board.
- Iterative subtract-and-count datapath, one subtraction per clock.

Parameters:
- SUM_W, 8, width of input sum and remainder output.
- N_W, 5, width of the n output; must satisfy n_max(2^SUM_W - 1) < 2^N_W. The default gives n_max = 22.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request level; sampled only in IDLE.
- sum_in  input  SUM_W  operand S; latched when the request is accepted.
- n_out  output  N_W  result n.
- rem_out  output  SUM_W  remainder R.
- exact  output  1  1 when R == 0.
- busy  output  1  high while in RUN.
- valid  output  1  high while in DONE; results are stable while valid is high.

Behaviour:
- Reset values: state=IDLE; n_out=0, rem_out=0, exact=0, busy=0, valid=0; internal rem, k and n cleared.
- States are IDLE, RUN and DONE; 2-bit encoding, registered state, single clock domain.
- IDLE:
  - On a clk edge with start=1: latch rem<=sum_in, k<=1, n<=0; go to RUN.
  - With start=0: stay in IDLE.
- RUN, each edge:
  - If rem >= k: rem<=rem-k, n<=k, k<=k+1; stay in RUN.
  - Else: load n_out<=n, rem_out<=rem, exact<=(rem==0); go to DONE.
  - k is N_W+1 bits wide and never wraps.
  - The comparison is unsigned, with k zero-extended to SUM_W or rem extended to N_W+1, whichever is wider.
- RUN ignores start and sum_in; the operation cannot be aborted except by rst.
- DONE:
  - Stay while start=1.
  - On start=0: go to IDLE.
  - n_out, rem_out and exact hold their values through DONE and IDLE until the next result is loaded.
- Outputs:
  - busy = (state==RUN); valid = (state==DONE); both decoded from the registered state.
  - Results are registered; there is no combinational path from inputs to outputs.
- Latency, with the accepting edge as edge 0:
  - Edges 1..n perform the subtractions.
  - Edge n+1 enters DONE, so valid first rises after edge n+1.
  - For S=0: n=0, and DONE is entered on edge 1.
- Boundary conditions:
  - S=0 gives n=0, R=0, exact=1.
  - S=2^SUM_W-1 (255) gives n=22, R=2, exact=0.
- start held high continuously: exactly one computation is performed. A new request needs start to be low for at least one cycle, which forces DONE back to IDLE.
- start going low during RUN: computation completes, enters DONE, then goes to IDLE on the next edge. valid is high for exactly one cycle.
- sum_in changing during RUN or DONE has no effect.
- rst low at any time, including mid-RUN: immediately forces IDLE and clears all outputs. The partial result is discarded.

Test Plan:
- S=10, start pulsed high one cycle, then held high: busy for 5 cycles, then valid=1 with n_out=4, rem_out=0, exact=1. Outputs hold while start stays high.
- S=12 → n_out=4, rem_out=2, exact=0. S=0 → valid after edge 1 with n_out=0, rem_out=0, exact=1.
- S=255 → n_out=22, rem_out=2, exact=0, valid after edge 23. Sweep S=0..255 against a reference model; also check exact=1 only for S in {0,1,3,6,10,...,253}.
- S=21 accepted, then sum_in changed to 5 and start dropped during RUN → result n_out=6, rem_out=0, exact=1. valid is high for one cycle, then IDLE with outputs retained.
- rst asserted for one cycle at edge 3 of a S=200 run → all outputs go to 0 asynchronously and state=IDLE. A new request with S=6 then gives n_out=3, rem_out=0, exact=1.
- Loopback: forward summing FSM with target t=0..22 drives sum_in → n_out==t and exact=1 for every t.
